sipo_deser: RTL
===============

SIPO_DESER -- requirements
Module: sipo_deser

Interface
- REQ-001 SHALL: parameter WIDTH, default 4, word length in bits; legal range 2..64.
- REQ-002 SHALL: parameter LSB_FIRST, default 1; 1 = first received bit lands in word bit 0, 0 = first received bit lands in word bit WIDTH-1.
- REQ-003 SHALL: localparam CW = clog2(WIDTH), width of bit counter.
- REQ-004 SHALL: clk  input  1  sole clock, all state updates on rising edge.
- REQ-005 SHALL: rst  input  1  asynchronous, active-low reset.
- REQ-006 SHALL: clr  input  1  synchronous clear of the partial word in progress.
- REQ-007 SHALL: din  input  1  serial data bit.
- REQ-008 SHALL: din_valid  input  1  din is sampled on this edge when high.
- REQ-009 SHALL: q  output  WIDTH  live shift-register contents.
- REQ-010 SHALL: bit_cnt  output  CW  bits accepted in the current word (0..WIDTH-1).
- REQ-011 SHALL: word_data  output  WIDTH  buffered completed word.
- REQ-012 SHALL: word_valid  output  1  word_data holds an unconsumed word.
- REQ-013 SHALL: word_ready  input  1  consumer accepts word_data when word_valid is high.
- REQ-014 SHALL: overflow  output  1  sticky flag; a completed word was dropped.
- REQ-015 SHALL: ovf_clr  input  1  synchronous clear of overflow.

Function
- REQ-016 SHALL: when LSB_FIRST=1, an accepted bit shifts q right (new bit into q[WIDTH-1], toward q[0]); when LSB_FIRST=0, it shifts q left (new bit into q[0]).
- REQ-017 SHALL: with din_valid low, q and bit_cnt hold; gaps between accepted bits are unlimited.
- REQ-018 SHALL: each accepted bit increments bit_cnt; on the WIDTH-th bit, bit_cnt wraps to 0.
- REQ-019 SHALL: on the WIDTH-th bit, the completed word (shift contents including that bit) is the word offered to the output buffer on the same edge.
- REQ-020 SHALL: output buffer has two states.
  - EMPTY: word_valid=0.
  - FULL: word_valid=1.
- REQ-021 SHALL: transfer word_valid && word_ready moves the buffer FULL->EMPTY, unless a new word loads on the same edge, in which case it stays FULL with the new word.
- REQ-022 SHALL: a completed word loads into the buffer when EMPTY or draining on that edge; word_valid rises at the same edge (latency 0 cycles after the final bit edge).
- REQ-023 SHALL: a completed word arriving while FULL and not draining is dropped; word_data keeps the old word and overflow sets.
- REQ-024 SHALL: word_data and word_valid remain stable while word_valid=1 and word_ready=0.
- REQ-025 SHALL: clr forces q=0 and bit_cnt=0 and has priority over a din_valid bit on the same edge; it does not affect word_data, word_valid or overflow.
- REQ-026 SHALL: ovf_clr clears overflow; a simultaneous new overflow event wins (overflow=1).
- REQ-027 SHALL: word_ready while EMPTY has no effect.

Reset
- REQ-028 SHALL: rst low asynchronously forces q=0, bit_cnt=0, word_data=0, word_valid=0 and overflow=0, including mid-word and mid-handshake.
- REQ-029 SHALL: after rst rises, the first accepted bit is bit 0 of a new word.

Verification
- REQ-030 SHALL: reset, WIDTH=4: rst low after 2 accepted bits -> all outputs 0 immediately; following bits 1,0,1,1 -> word_data=4'b1101.
- REQ-031 SHALL: WIDTH=4, LSB_FIRST=1, word_ready=1: din 1,0,1,1 on consecutive valid cycles -> word_valid high one cycle, word_data=4'b1101, bit_cnt back to 0.
- REQ-032 SHALL: WIDTH=4, LSB_FIRST=0: same stream -> word_data=4'b1011; WIDTH=8 stream 0xA5 (LSB first) with din_valid toggling every other cycle -> word_data=8'hA5.
- REQ-033 SHALL: backpressure, word_ready=0: words 4'h3 then 4'hC -> word_data stays 4'h3, overflow=1; then word_ready=1 -> word_valid drops; ovf_clr -> overflow=0.
- REQ-034 SHALL: simultaneous drain+load: buffer FULL with 4'h3, word_ready=1 on the edge completing 4'h9 -> word_valid stays 1, word_data=4'h9, overflow stays 0.
- REQ-035 SHALL: clr with din_valid=1 after 2 bits -> bit_cnt=0, q=0, bit discarded; next 4 bits form the next word intact.

Source files
------------

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with a one-word output buffer.
// Completed words load into the buffer on their final bit edge; words that cannot be buffered set a sticky overflow flag.
module sipo_deser #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1,
    localparam int unsigned CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] q,
    output logic [CW-1:0]    bit_cnt,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    input  logic             ovf_clr
);

    typedef enum logic [0:0] {StEmpty, StFull} buf_state_e;

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_next;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             word_done;
    logic             load;
    logic             ovf_set;

    // Shift register and bit counter
    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        if (LSB_FIRST) begin
            word_next = {din, shift_q[WIDTH-1:1]};
        end else begin
            word_next = {shift_q[WIDTH-2:0], din};
        end
        if (clr) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (din_valid) begin
            shift_d = word_next;
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Output buffer: a load on the draining edge replaces the word instead of emptying
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovf_set = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (word_done) begin
                    load    = 1'b1;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (word_done) begin
                    if (word_ready) begin
                        load = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end else if (word_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        data_d = load ? word_next : data_q;
        ovf_d  = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StEmpty;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q          = shift_q;
    assign bit_cnt    = cnt_q;
    assign word_data  = data_q;
    assign word_valid = (state_q == StFull);
    assign overflow   = ovf_q;

endmodule
